// File: rtl/uart_tx_drain.sv
// Drains a first-word-fallthrough byte FIFO into 8N1 UART frames on o_tx, popping one byte per frame.
// Define UART_TX_PARITY_EN to add an even-parity bit after bit 7 (8E1, 11-bit frames).
module uart_tx_drain #(
  parameter int DIVISOR = 104,
  localparam int CBITS = $clog2(DIVISOR)
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_data_available,
  input  logic [7:0] i_read_data,
  output logic       o_read_strobe,
  output logic       o_tx,
  output logic       o_busy
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [CBITS-1:0] BAUD_LAST = CBITS'(DIVISOR - 1);

  state_t           r_state, w_state_next;
  logic [CBITS-1:0] r_baud, w_baud_next;
  logic [2:0]       r_bit, w_bit_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_tx, w_tx_next;
  logic             r_strobe, w_strobe_next;
  logic             w_baud_last;
  logic             w_load;
`ifdef UART_TX_PARITY_EN
  logic             r_parity, w_parity_next;
`endif

  assign w_baud_last   = (r_baud == BAUD_LAST);
  assign o_tx          = r_tx;
  assign o_read_strobe = r_strobe;
  assign o_busy        = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_tx     <= 1'b1;
      r_strobe <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_strobe <= w_strobe_next;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    w_strobe_next = 1'b0;
    w_load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_load = i_data_available;
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_next = S_DATA;
          w_baud_next  = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_parity;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_state_next = S_STOP;
          w_baud_next  = '0;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (i_data_available) begin
            w_load = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_bit_next   = 3'd0;
        w_tx_next    = 1'b1;
      end
    endcase

    // Shared by IDLE and the back-to-back path out of STOP so streaming adds no gap.
    if (w_load) begin
      w_state_next  = S_START;
      w_baud_next   = '0;
      w_shift_next  = i_read_data;
      w_strobe_next = 1'b1;
      w_tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity_next = ^i_read_data;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: two instances (DIVISOR 4 and 2) each fed by a small FIFO model.
module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem4 [0:31];
  logic [7:0] mem2 [0:31];
  int wr4 = 0;
  int rd4 = 0;
  int wr2 = 0;
  int rd2 = 0;

  logic       da4, da2, st4, st2, tx4, tx2, bz4, bz2;
  logic [7:0] rdat4, rdat2;

  assign da4   = (wr4 != rd4);
  assign rdat4 = mem4[rd4[4:0]];
  assign da2   = (wr2 != rd2);
  assign rdat2 = mem2[rd2[4:0]];

  always @(posedge clk) begin
    if (st4) rd4 <= rd4 + 1;
    if (st2) rd2 <= rd2 + 1;
  end

  uart_tx_drain #(.DIVISOR(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data_available(da4), .i_read_data(rdat4),
    .o_read_strobe(st4), .o_tx(tx4), .o_busy(bz4)
  );

  uart_tx_drain #(.DIVISOR(2)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data_available(da2), .i_read_data(rdat2),
    .o_read_strobe(st2), .o_tx(tx2), .o_busy(bz2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_bytes [0:15];

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, expv);
    end
  endtask

  // Expected line level for bit slot k of a frame (0 = start, 1..8 = data LSB first).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic idle_check(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk({tag, ".tx4"}, c, 32'(tx4), 32'd1);
      chk({tag, ".st4"}, c, 32'(st4), 32'd0);
      chk({tag, ".bz4"}, c, 32'(bz4), 32'd0);
      chk({tag, ".tx2"}, c, 32'(tx2), 32'd1);
      chk({tag, ".st2"}, c, 32'(st2), 32'd0);
      chk({tag, ".bz2"}, c, 32'(bz2), 32'd0);
    end
  endtask

  // Pushes exp_bytes[0..n-1] at once, then checks every cycle of the streamed frames.
  task automatic run_stream(input string tag, input int sel, input int n);
    int d;
    int f;
    logic etx;
    d = (sel != 0) ? 2 : 4;
    f = NB * d;
    for (int k = 0; k < n; k++) begin
      if (sel != 0) begin
        mem2[wr2[4:0]] = exp_bytes[k];
        wr2++;
      end else begin
        mem4[wr4[4:0]] = exp_bytes[k];
        wr4++;
      end
    end
    for (int i = 0; i <= n * f; i++) begin
      @(negedge clk);
      etx = (i < n * f) ? exp_bit(exp_bytes[i / f], (i % f) / d) : 1'b1;
      chk({tag, ".tx"}, i, 32'((sel != 0) ? tx2 : tx4), 32'(etx));
      chk({tag, ".busy"}, i, 32'((sel != 0) ? bz2 : bz4), 32'(i < n * f));
      chk({tag, ".strobe"}, i, 32'((sel != 0) ? st2 : st4), 32'((i % f == 0) && (i < n * f)));
    end
    chk({tag, ".pops"}, n, 32'((sel != 0) ? rd2 : rd4), 32'((sel != 0) ? wr2 : wr4));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.tx4", 0, 32'(tx4), 32'd1);
    chk("rst.bz4", 0, 32'(bz4), 32'd0);
    chk("rst.st4", 0, 32'(st4), 32'd0);
    chk("rst.tx2", 0, 32'(tx2), 32'd1);
    rst_n = 1'b1;

    idle_check("empty", 500);

    exp_bytes[0] = 8'h55;
    run_stream("b55", 0, 1);

    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h3C;
    run_stream("pair", 0, 2);

    exp_bytes[0] = 8'h07;
    exp_bytes[1] = 8'h03;
    run_stream("par", 0, 2);

    // Abandon a 0xFF frame at cycle 13, then send 0x81.
    mem4[wr4[4:0]] = 8'hFF;
    wr4++;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("pre.tx", i, 32'(tx4), 32'(exp_bit(8'hFF, i / 4)));
      chk("pre.busy", i, 32'(bz4), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("inrst.tx", 0, 32'(tx4), 32'd1);
    chk("inrst.busy", 0, 32'(bz4), 32'd0);
    chk("inrst.strobe", 0, 32'(st4), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("inrst.tx", c, 32'(tx4), 32'd1);
      chk("inrst.busy", c, 32'(bz4), 32'd0);
      chk("inrst.strobe", c, 32'(st4), 32'd0);
    end
    rst_n = 1'b1;
    chk("rst.pops", 0, 32'(rd4), 32'(wr4));
    idle_check("postrst", 3);
    exp_bytes[0] = 8'h81;
    run_stream("b81", 0, 1);

    for (int k = 0; k < 16; k++) exp_bytes[k] = 8'(k);
    run_stream("d2s", 1, 16);
    chk("d2s.count", 0, 32'(rd2), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
